// File: rtl/lrck_gen.sv
// I2S clock generator: divides MCLK into a bit clock (o_sclk) and word-select clock (o_lrck).
// Latency: first o_sclk rise M/2 enabled edges after i_oe goes high; both outputs are flop outputs.
// No backpressure; dropping i_oe clears both counters and forces the outputs low on the next edge.
module lrck_gen #(
    parameter int C_LRCK_SCLK_RATIO = 64,
    parameter int C_MCLK_SCLK_RATIO = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_oe,
    output logic o_sclk,
    output logic o_lrck
);

    localparam int HALF_M = C_MCLK_SCLK_RATIO / 2;
    localparam int HALF_L = C_LRCK_SCLK_RATIO / 2;
    localparam int HW     = (HALF_M > 1) ? $clog2(HALF_M) : 1;
    localparam int BW     = (HALF_L > 1) ? $clog2(HALF_L) : 1;

    localparam logic [HW-1:0] H_LAST = HW'(HALF_M - 1);
    localparam logic [BW-1:0] B_LAST = BW'(HALF_L - 1);

    generate
        if ((C_MCLK_SCLK_RATIO % 2) != 0 || C_MCLK_SCLK_RATIO < 2) begin : g_bad_mclk_ratio
            $error("lrck_gen: C_MCLK_SCLK_RATIO must be even and >= 2");
        end
        if ((C_LRCK_SCLK_RATIO % 2) != 0 || C_LRCK_SCLK_RATIO < 2) begin : g_bad_lrck_ratio
            $error("lrck_gen: C_LRCK_SCLK_RATIO must be even and >= 2");
        end
    endgenerate

    logic [HW-1:0] h;
    logic [BW-1:0] b;
    logic          sclk_q;
    logic          lrck_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_oe) begin
            // Idle shares the reset clear so every enable restarts at phase 0, left channel.
            h      <= '0;
            b      <= '0;
            sclk_q <= 1'b0;
            lrck_q <= 1'b0;
        end else if (h == H_LAST) begin
            h      <= '0;
            sclk_q <= ~sclk_q;
            // Word select only advances on the edge where the bit clock falls.
            if (sclk_q) begin
                if (b == B_LAST) begin
                    b      <= '0;
                    lrck_q <= ~lrck_q;
                end else begin
                    b <= b + 1'b1;
                end
            end
        end else begin
            h <= h + 1'b1;
        end
    end

    assign o_sclk = sclk_q;
    assign o_lrck = lrck_q;

endmodule

// File: tb/tb_lrck_gen.sv
// Bench for lrck_gen: two instances (L=32/M=2 and default L=64/M=4) driven by shared reset/enable.
module tb_lrck_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic oe;
    logic sclk_a, lrck_a;
    logic sclk_b, lrck_b;

    lrck_gen #(
        .C_LRCK_SCLK_RATIO(32),
        .C_MCLK_SCLK_RATIO(2)
    ) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .i_oe  (oe),
        .o_sclk(sclk_a),
        .o_lrck(lrck_a)
    );

    lrck_gen dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .i_oe  (oe),
        .o_sclk(sclk_b),
        .o_lrck(lrck_b)
    );

    typedef struct {
        logic rst;
        logic oe;
        int   cyc;
        logic exp_sclk;
        logic exp_lrck;
    } vec_t;

    vec_t tbl[15];

    int   total = 0;
    int   bad   = 0;
    int   n     = 0;   // consecutive enabled edges since the last clear
    logic pa_s = 1'b0, pa_l = 1'b0, pb_s = 1'b0, pb_l = 1'b0;

    // Reference: after n enabled edges the bit clock has toggled n/(M/2) times,
    // word select has toggled once per L/2 bit-clock falls.
    function automatic bit ref_sclk(int cnt, int m);
        return bit'((cnt / (m / 2)) % 2);
    endfunction

    function automatic bit ref_lrck(int cnt, int m, int l);
        int falls;
        falls = (cnt / (m / 2)) / 2;
        return bit'((falls / (l / 2)) % 2);
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (enabled edges=%0d, t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic check_align(input string name, input logic ps, input logic s);
        total++;
        if (!(ps === 1'b1 && s === 1'b0)) begin
            bad++;
            $display("FAIL %s: lrck moved with sclk %b->%b, required 1->0 (t=%0t)", name, ps, s, $time);
        end
    endtask

    task automatic tick();
        bit running;
        @(posedge clk);
        #1;
        running = !rst && oe;
        if (running) n++;
        else         n = 0;
        check1("model_sclk_a", sclk_a, ref_sclk(n, 2));
        check1("model_lrck_a", lrck_a, ref_lrck(n, 2, 32));
        check1("model_sclk_b", sclk_b, ref_sclk(n, 4));
        check1("model_lrck_b", lrck_b, ref_lrck(n, 4, 64));
        if (running && lrck_a !== pa_l) check_align("align_a", pa_s, sclk_a);
        if (running && lrck_b !== pb_l) check_align("align_b", pb_s, sclk_b);
        pa_s = sclk_a; pa_l = lrck_a;
        pb_s = sclk_b; pb_l = lrck_b;
    endtask

    initial begin
        // Hand-derived values for the L=32, M=2 instance.
        tbl[0]  = '{1'b1, 1'b0, 4096, 1'b0, 1'b0};  // long reset
        tbl[1]  = '{1'b0, 1'b1, 1,    1'b1, 1'b0};  // M=2: sclk high right after first edge
        tbl[2]  = '{1'b0, 1'b1, 30,   1'b1, 1'b0};  // edge 31, still left
        tbl[3]  = '{1'b0, 1'b1, 1,    1'b0, 1'b1};  // edge 32: first lrck rise
        tbl[4]  = '{1'b0, 1'b1, 32,   1'b0, 1'b0};  // edge 64: back to left
        tbl[5]  = '{1'b0, 1'b1, 5,    1'b1, 1'b0};  // mid-frame, sclk high
        tbl[6]  = '{1'b0, 1'b0, 1,    1'b0, 1'b0};  // drop oe: low next edge
        tbl[7]  = '{1'b0, 1'b0, 6,    1'b0, 1'b0};  // 7 idle cycles total
        tbl[8]  = '{1'b0, 1'b1, 32,   1'b0, 1'b1};  // re-enable: rise at 32 again
        tbl[9]  = '{1'b0, 1'b0, 1,    1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 31,   1'b1, 1'b0};  // next edge would raise lrck
        tbl[11] = '{1'b1, 1'b1, 1,    1'b0, 1'b0};  // reset on that toggle edge wins
        tbl[12] = '{1'b0, 1'b1, 32,   1'b0, 1'b1};  // restart from phase 0
        tbl[13] = '{1'b0, 1'b1, 640,  1'b0, 1'b1};  // edge 672, >10 frames
        tbl[14] = '{1'b0, 1'b0, 1,    1'b0, 1'b0};

        rst = 1'b1;
        oe  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            rst = tbl[i].rst;
            oe  = tbl[i].oe;
            repeat (tbl[i].cyc) tick();
            check1($sformatf("vec%0d_sclk", i), sclk_a, tbl[i].exp_sclk);
            check1($sformatf("vec%0d_lrck", i), lrck_a, tbl[i].exp_lrck);
        end

        // M=4, L=64 instance: first rise on the second enabled edge, lrck period 256.
        rst = 1'b1; oe = 1'b0; tick();
        rst = 1'b0; oe = 1'b1;
        tick();            check1("b_edge1_sclk", sclk_b, 1'b0);
        tick();            check1("b_edge2_sclk", sclk_b, 1'b1);
        tick();            check1("b_edge3_sclk", sclk_b, 1'b1);
        tick();            check1("b_edge4_sclk", sclk_b, 1'b0);
        repeat (123) tick(); check1("b_edge127_lrck", lrck_b, 1'b0);
        tick();            check1("b_edge128_lrck", lrck_b, 1'b1);
        repeat (128) tick(); check1("b_edge256_lrck", lrck_b, 1'b0);

        // Random enable/reset traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r   = int'($urandom_range(0, 199));
            rst = (r < 2);
            oe  = !(r >= 2 && r < 8);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
